// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the multiply/divide FSM state type.
package riscv_pkg;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// sharing one 2*XLEN accumulator; stalls the pipeline until Done.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            Start,
    input  logic            Flush,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            Stall,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output muldiv_state_t   fsm_state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state, state_next;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc, acc_next, prod;
    logic [XLEN-1:0]   opnd;
    logic [2:0]        op;
    logic              sign_a, sign_b;

    logic              is_m, accept, in_div, in_signed_div, in_sa, in_sb;
    logic              div_zero, div_ovf, fast, last_iter;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res, final_res, quo, rem;
    logic [XLEN:0]     mul_sum, rem_sh, trial;

    assign is_m          = (ALUOp == ALUOP_RTYPE) && (Funct7 == MULDIV_FUNCT7);
    assign accept        = (state == IDLE) && Start && is_m && !Flush;
    assign in_div        = Funct3[2];
    assign in_signed_div = in_div && !Funct3[0];
    assign in_sa = SrcA[XLEN-1] && (Funct3 == F3_MULH || Funct3 == F3_MULHSU || in_signed_div);
    assign in_sb = SrcB[XLEN-1] && (Funct3 == F3_MULH || in_signed_div);
    assign mag_a = in_sa ? -SrcA : SrcA;
    assign mag_b = in_sb ? -SrcB : SrcB;

    assign div_zero  = in_div && (SrcB == '0);
    assign div_ovf   = in_signed_div && (SrcA == MIN_NEG) && (SrcB == '1);
    assign fast      = div_zero || div_ovf;
    assign last_iter = (count == CW'(XLEN - 1));

    // Reset gates Stall so a held Start cannot freeze the pipeline during reset.
    assign Stall     = reset && (accept || state == CALC);
    assign Done      = (state == DONE);
    assign fsm_state = state;

    always_comb begin
        fast_res = '1;
        if (div_zero) fast_res = Funct3[1] ? SrcA : '1;
        else if (div_ovf) fast_res = Funct3[1] ? '0 : MIN_NEG;
    end

    always_comb begin
        state_next = state;
        if (Flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = fast ? DONE : CALC;
                CALC:    if (last_iter) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // One iteration: multiply keeps {product_hi, multiplier} and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh  = acc[2*XLEN-1:XLEN-1];
        trial   = rem_sh - {1'b0, opnd};
        if (op[2]) begin
            if (trial[XLEN]) acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else             acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc_next : acc_next;
        quo  = (sign_a ^ sign_b) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem  = sign_a ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        if (op[2])              final_res = op[1] ? rem : quo;
        else if (op == F3_MUL)  final_res = prod[XLEN-1:0];
        else                    final_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            Result <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op     <= Funct3;
                    sign_a <= in_sa;
                    sign_b <= in_sb;
                    count  <= '0;
                    opnd   <= in_div ? mag_b : mag_a;
                    acc    <= {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
                    if (fast) Result <= fast_res;
                end
                CALC: if (!Flush) begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (last_iter) Result <= final_res;
                end
                default: ;
            endcase
        end
    end

endmodule
